// File: rtl/dice_roll_gen_if.sv
// Request/result bundle for dice_roll_gen; signal prefixes are from the roller's point of view.
// Optional SUM signal exists only when DICE_SUM_EN is defined.
interface dice_roll_gen_if #(
  parameter int WIDTH  = 7,
  parameter int N_DICE = 2
);
  localparam int SUM_W = WIDTH + $clog2(N_DICE) + 1;

  logic                      i_start;
  logic [WIDTH-1:0]          i_nb_face;
  logic                      i_zero_base;
  logic                      o_busy;
  logic                      o_valid;
  logic                      o_err;
  logic [N_DICE*WIDTH-1:0]   o_result;
`ifdef DICE_SUM_EN
  logic [SUM_W-1:0]          o_sum;

  modport master (output i_start, i_nb_face, i_zero_base,
                  input  o_busy, o_valid, o_err, o_result, o_sum);
  modport slave  (input  i_start, i_nb_face, i_zero_base,
                  output o_busy, o_valid, o_err, o_result, o_sum);
`else
  modport master (output i_start, i_nb_face, i_zero_base,
                  input  o_busy, o_valid, o_err, o_result);
  modport slave  (input  i_start, i_nb_face, i_zero_base,
                  output o_busy, o_valid, o_err, o_result);
`endif
endinterface

// File: rtl/dice_roll_gen.sv
// Sequential N_DICE roller: free-running Galois LFSR, range reduction by repeated subtraction.
// Define DICE_SUM_EN to add the o_sum output (total of all dice, updated with o_valid).
module dice_roll_gen #(
  parameter int                WIDTH  = 7,
  parameter int                N_DICE = 2,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
)(
  input  logic           i_clk,
  input  logic           i_rst,
  dice_roll_gen_if.slave bus
);
  localparam int ACC_W = WIDTH + 1;
  localparam int IDX_W = (N_DICE > 1) ? $clog2(N_DICE) : 1;
  localparam logic [LFSR_W-1:0] MASK = LFSR_W'(16'hB400);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_REDUCE = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]              r_state;
  logic [LFSR_W-1:0]       r_lfsr;
  logic [WIDTH-1:0]        r_face;
  logic                    r_zb;
  logic [IDX_W-1:0]        r_idx;
  logic [ACC_W-1:0]        r_acc;
  logic                    r_busy;
  logic                    r_valid;
  logic                    r_err;
  logic [N_DICE*WIDTH-1:0] r_result;

  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic [ACC_W-1:0]  w_face_ext;
  logic              w_acc_ge;
  logic [WIDTH-1:0]  w_die_val;
  logic              w_last;
  logic              w_face_ok;

  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ MASK) : (r_lfsr >> 1);
  assign w_face_ext = {1'b0, r_face};
  assign w_acc_ge   = (r_acc >= w_face_ext);
  assign w_die_val  = r_acc[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, ~r_zb};
  assign w_last     = (r_idx == IDX_W'(N_DICE - 1));
  assign w_face_ok  = (bus.i_nb_face >= WIDTH'(2));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= SEED;
    else       r_lfsr <= w_lfsr_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_face   <= '0;
      r_zb     <= 1'b0;
      r_idx    <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            if (w_face_ok) begin
              r_face  <= bus.i_nb_face;
              r_zb    <= bus.i_zero_base;
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_SAMPLE;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_SAMPLE: begin
          r_acc   <= r_lfsr[ACC_W-1:0];
          r_state <= S_REDUCE;
        end
        S_REDUCE: begin
          if (w_acc_ge) begin
            r_acc <= r_acc - w_face_ext;
          end else begin
            r_result[r_idx*WIDTH +: WIDTH] <= w_die_val;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_last) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            // Later dice sample here directly, keeping each die at 2 + raw/F cycles.
            r_idx   <= r_idx + 1'b1;
            r_acc   <= r_lfsr[ACC_W-1:0];
            r_state <= S_REDUCE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DICE_SUM_EN
  localparam int SUM_W = WIDTH + $clog2(N_DICE) + 1;
  logic [WIDTH-1:0] r_die;
  logic [SUM_W-1:0] r_sum_acc;
  logic [SUM_W-1:0] r_sum;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_die     <= '0;
      r_sum_acc <= '0;
      r_sum     <= '0;
    end else begin
      if (r_state == S_IDLE && bus.i_start && w_face_ok)
        r_sum_acc <= '0;
      if (r_state == S_REDUCE && !w_acc_ge)
        r_die <= w_die_val;
      if (r_state == S_NEXT) begin
        if (w_last) r_sum     <= r_sum_acc + SUM_W'(r_die);
        else        r_sum_acc <= r_sum_acc + SUM_W'(r_die);
      end
    end
  end

  assign bus.o_sum = r_sum;
`endif

  assign bus.o_busy   = r_busy;
  assign bus.o_valid  = r_valid;
  assign bus.o_err    = r_err;
  assign bus.o_result = r_result;
endmodule

// File: tb/tb_dice_roll_gen.sv
// Directed bench for dice_roll_gen: an LFSR reference model predicts every die value and the latency.
module tb_dice_roll_gen;
  localparam int W     = 7;
  localparam int N     = 2;
  localparam int SUM_W = W + $clog2(N) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   vcount = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  dice_roll_gen_if #(.WIDTH(W), .N_DICE(N)) bus();
  dice_roll_gen #(.WIDTH(W), .N_DICE(N)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  function automatic logic [15:0] step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= step(m_lfsr);
  end

  always @(negedge clk) if (bus.o_valid === 1'b1) vcount++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // x0 is the LFSR value in the cycle START is sampled.
  task automatic predict(input logic [15:0] x0, input logic [W-1:0] f, input logic zb,
                         output logic [N*W-1:0] res, output int lat, output int sm);
    logic [15:0] x;
    int raw, k, v;
    x = step(x0); lat = 2; sm = 0; res = '0;
    for (int d = 0; d < N; d++) begin
      raw = int'(x[W:0]);
      k   = raw / int'(f);
      v   = raw % int'(f) + (zb ? 0 : 1);
      res[d*W +: W] = W'(v);
      sm  += v;
      lat += 2 + k;
      for (int j = 0; j < k + 2; j++) x = step(x);
    end
  endtask

  task automatic do_roll(input logic [W-1:0] f, input logic zb, input string tag,
                         output logic [N*W-1:0] got);
    logic [N*W-1:0] er;
    int el, es, n;
    bit seen;
    @(negedge clk);
    predict(m_lfsr, f, zb, er, el, es);
    bus.i_start = 1'b1; bus.i_nb_face = f; bus.i_zero_base = zb;
    n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      n++;
      if (n == 1) chk({tag, " busy"}, 64'(bus.o_busy), 64'd1);
      if (bus.o_valid === 1'b1) seen = 1;
    end
    chk({tag, " valid seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'(el));
    chk({tag, " result"}, 64'(bus.o_result), 64'(er));
    chk({tag, " busy at valid"}, 64'(bus.o_busy), 64'd0);
`ifdef DICE_SUM_EN
    chk({tag, " sum"}, 64'(bus.o_sum), 64'(es));
`endif
    got = bus.o_result;
  endtask

  initial begin
    logic [N*W-1:0] got, prev, er;
    int hist[128];
    int bad, v0, el, es, n;
    bit seen;

    bus.i_start = 1'b0; bus.i_nb_face = '0; bus.i_zero_base = 1'b0;
    #2 rst = 1'b1;
    #10;
    chk("reset busy",   64'(bus.o_busy),   64'd0);
    chk("reset valid",  64'(bus.o_valid),  64'd0);
    chk("reset err",    64'(bus.o_err),    64'd0);
    chk("reset result", 64'(bus.o_result), 64'd0);
`ifdef DICE_SUM_EN
    chk("reset sum",    64'(bus.o_sum),    64'd0);
`endif
    @(negedge clk); rst = 1'b0;

    // Illegal face counts are refused with a one-cycle ERR
    prev = bus.o_result;
    for (int f = 0; f < 2; f++) begin
      v0 = vcount;
      @(negedge clk);
      bus.i_start = 1'b1; bus.i_nb_face = W'(f);
      @(negedge clk);
      bus.i_start = 1'b0;
      chk($sformatf("err F=%0d", f), 64'(bus.o_err), 64'd1);
      chk($sformatf("err busy F=%0d", f), 64'(bus.o_busy), 64'd0);
      @(negedge clk);
      chk($sformatf("err pulse F=%0d", f), 64'(bus.o_err), 64'd0);
      repeat (5) @(negedge clk);
      chk($sformatf("err no valid F=%0d", f), 64'(vcount - v0), 64'd0);
      chk($sformatf("err result F=%0d", f), 64'(bus.o_result), 64'(prev));
    end

    // d6, one-based
    for (int v = 0; v < 128; v++) hist[v] = 0;
    bad = 0; v0 = vcount;
    for (int r = 0; r < 300; r++) begin
      do_roll(7'd6, 1'b0, "d6", got);
      for (int d = 0; d < N; d++) begin
        if (got[d*W +: W] < 1 || got[d*W +: W] > 6) bad++;
        hist[got[d*W +: W]]++;
      end
    end
    repeat (3) @(negedge clk);
    chk("d6 range", 64'(bad), 64'd0);
    chk("d6 valid count", 64'(vcount - v0), 64'd300);
    for (int v = 1; v <= 6; v++) chk($sformatf("d6 hist %0d", v), 64'(hist[v] >= 50), 64'd1);

    // Reset mid-roll, two cycles after START the FSM is reducing die 0
    prev = bus.o_result;
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_nb_face = 7'd2; bus.i_zero_base = 1'b0;
    @(negedge clk); bus.i_start = 1'b0;
    @(negedge clk);
    chk("pre-reset busy", 64'(bus.o_busy), 64'd1);
    rst = 1'b1; v0 = vcount;
    #1;
    chk("midroll busy",   64'(bus.o_busy),    64'd0);
    chk("midroll valid",  64'(bus.o_valid),   64'd0);
    chk("midroll result", 64'(bus.o_result),  64'd0);
    chk("midroll lfsr",   64'(dut.r_lfsr),    64'hACE1);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midroll no valid", 64'(vcount - v0), 64'd0);
    chk("midroll idle", 64'(bus.o_busy), 64'd0);

    // d10 and d100 zero-based
    for (int t = 0; t < 2; t++) begin
      int f, rolls;
      bit lo, hi;
      f = (t == 0) ? 10 : 100;
      rolls = (t == 0) ? 100 : 600;
      bad = 0; lo = 0; hi = 0;
      for (int r = 0; r < rolls; r++) begin
        do_roll(W'(f), 1'b1, $sformatf("d%0d", f), got);
        for (int d = 0; d < N; d++) begin
          if (int'(got[d*W +: W]) > f - 1) bad++;
          if (got[d*W +: W] == 0) lo = 1;
          if (int'(got[d*W +: W]) == f - 1) hi = 1;
        end
      end
      chk($sformatf("d%0d range", f), 64'(bad), 64'd0);
      chk($sformatf("d%0d saw 0", f), 64'(lo), 64'd1);
      chk($sformatf("d%0d saw max", f), 64'(hi), 64'd1);
    end

    // F=127 one-based: maximum face count
    bad = 0;
    for (int r = 0; r < 100; r++) begin
      do_roll(7'd127, 1'b0, "d127", got);
      for (int d = 0; d < N; d++)
        if (got[d*W +: W] < 1) bad++;
    end
    chk("d127 range", 64'(bad), 64'd0);

    // START pulses and input changes while busy are ignored
    @(negedge clk);
    predict(m_lfsr, 7'd127, 1'b0, er, el, es);
    bus.i_start = 1'b1; bus.i_nb_face = 7'd127; bus.i_zero_base = 1'b0;
    v0 = vcount; n = 0; seen = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      bus.i_nb_face = 7'd3; bus.i_zero_base = 1'b1;
      bus.i_start = (n % 2 == 1 && n < el) ? 1'b1 : 1'b0;
      if (bus.o_valid === 1'b1) seen = 1;
    end
    bus.i_start = 1'b0;
    chk("busy-start valid seen", 64'(seen), 64'd1);
    chk("busy-start latency", 64'(n), 64'(el));
    chk("busy-start result", 64'(bus.o_result), 64'(er));
    repeat (10) @(negedge clk);
    chk("busy-start one valid", 64'(vcount - v0), 64'd1);
    chk("busy-start idle", 64'(bus.o_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
